fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage that decouples the PC and instruction memory from decode.
- Holds a fetch PC and issues read requests to a stalling instruction memory, with at most one request outstanding.
- Buffers returned instructions, tagged with their PC and PC+INC, in a DEPTH-entry FIFO.
- Presents FIFO entries to decode with a valid/ready handshake.
- A redirect (branch, jump or exception) flushes the FIFO and discards any in-flight response.

Parameters:
- WIDTH, 16: instruction and address width.
- DEPTH, 4: FIFO entries; power of two, 2 or more.
- RESET_PC, 0: fetch PC after reset.
- INC, 2: sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new memory requests.
- redirect_valid  in  1  flush and reload the fetch PC.
- redirect_pc  in  WIDTH  new fetch PC.
- mem_rd  out  1  read request.
- mem_addr  out  WIDTH  request address; always equals the fetch PC.
- mem_stall  in  1  request not accepted this cycle.
- mem_done  in  1  read data valid.
- mem_rdata  in  WIDTH  read data.
- mem_err  in  1  error, qualified by mem_done.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  WIDTH  head instruction.
- out_pc  out  WIDTH  head PC.
- out_pc_inc  out  WIDTH  head PC + INC, modulo 2^WIDTH.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky error.

Behaviour:
- Reset, rst = 0, asynchronous:
  - fetch PC = RESET_PC; state = IDLE; count = 0; read and write pointers = 0; err = 0.
  - Outputs: mem_rd = 0, out_valid = 0, out_instr = 0, out_pc = 0, out_pc_inc = 0.
  - Reset mid-request abandons the request; a late mem_done arriving in IDLE is ignored.
- States: IDLE, WAIT, DROP, HALT.
- Request issue: mem_rd is high when all of the following hold:
  - fetch_en = 1 and redirect_valid = 0;
  - the state is IDLE, or the state is WAIT and mem_done = 1 this cycle;
  - (count − pop + push) < DEPTH, evaluated for this cycle's pop and push.
- Request acceptance: a request is accepted when mem_rd = 1 and mem_stall = 0.
  - The request PC is latched as the tag.
  - fetch PC <= fetch PC + INC, wrapping modulo 2^WIDTH.
  - Next state = WAIT.
- If mem_rd = 1 and mem_stall = 1: mem_addr is held and mem_rd is re-evaluated next cycle.
- WAIT with mem_done = 1 and mem_err = 0:
  - push {mem_rdata, tag, tag+INC} at the write pointer.
  - Next state is WAIT if a new request is accepted the same cycle, otherwise IDLE.
- WAIT with mem_done = 1 and mem_err = 1: no push; err <= 1; next state HALT.
- HALT: mem_rd = 0 permanently; the FIFO still drains; only reset exits HALT.
- Pop: occurs when out_valid = 1, out_ready = 1 and redirect_valid = 0.
  - Head outputs come combinationally from the read-pointer entry.
  - Pop and push in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH because space is reserved at issue.
- out_instr, out_pc and out_pc_inc are 0 whenever out_valid = 0.
- Redirect has the highest priority and applies in any state except HALT:
  - count <= 0; pointers <= 0; no push and no pop that cycle; fetch PC <= redirect_pc.
  - From WAIT with mem_done = 0: next state DROP.
  - From WAIT with mem_done = 1: the response is discarded; next state IDLE.
  - From IDLE: stay IDLE.
  - From DROP: stay DROP.
- Misaligned redirect (redirect_pc mod INC ≠ 0): err <= 1; next state is DROP if a request is outstanding, otherwise HALT.
- DROP: mem_rd = 0.
  - On mem_done the data is discarded and mem_err is ignored; next state IDLE.
  - A misaligned redirect took place if err = 1; in that case next state is HALT instead of IDLE.
- Latency: with mem_stall = 0 and 1-cycle mem_done, first out_valid occurs 2 cycles after reset release with fetch_en = 1.
- Steady-state throughput: 1 instruction per cycle while mem_done returns the cycle after acceptance.

Test Plan:
- Reset release, fetch_en = 1, 1-cycle memory, out_ready = 1: mem_addr reads 0,2,4,6; out_pc follows 0,2,4 with out_pc_inc = 2,4,6; count ≤ 1.
- out_ready = 0, DEPTH = 4: exactly 4 requests are accepted; count = 4; mem_rd stays 0. One pop then re-enables issue; count never reaches 5.
- mem_stall high for 3 cycles on address 0x0004: mem_addr is held at 0x0004; exactly one push with out_pc = 0x0004.
- Redirect to 0x0100 while in WAIT with 2 entries queued:
  - count = 0 next cycle; the in-flight response (PC 0x0006) is dropped.
  - Next request address is 0x0100; first out_pc = 0x0100.
- mem_err on the response for PC 0x0008:
  - err = 1 and stays 1; mem_rd stays 0.
  - The remaining FIFO entries drain; reset clears err.
- Fetch PC 0xFFFE, INC = 2: out_pc_inc = 0x0000; next mem_addr = 0x0000. Separately, redirect_pc = 0x0003 sets err.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode-side stream.
// master is the fetch queue's view; slave is the memory/decode environment's view.
interface fetch_queue_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_rd;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_stall;
  logic             mem_done;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_err;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_pc_inc;

  modport master (
    output mem_rd, mem_addr, out_valid, out_instr, out_pc, out_pc_inc,
    input  mem_stall, mem_done, mem_rdata, mem_err, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_valid, out_instr, out_pc, out_pc_inc,
    output mem_stall, mem_done, mem_rdata, mem_err, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: one-outstanding-request PC sequencer feeding a DEPTH-entry instruction FIFO,
// with redirect flush, in-flight response dropping and a sticky error halt.
module fetch_queue #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned INC      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_pc,
  fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop, StHalt} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] fetch_pc_q;
  logic [WIDTH-1:0] tag_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [WIDTH-1:0] fifo_instr_q  [DEPTH];
  logic [WIDTH-1:0] fifo_pc_q     [DEPTH];
  logic [WIDTH-1:0] fifo_pc_inc_q [DEPTH];

  logic          issue_state, push, pop, accept, inflight, misaligned;
  logic [CW:0]   occ_next;

  always_comb begin
    bus.out_valid = (count_q != '0);
    issue_state   = (state_q == StIdle) ||
                    ((state_q == StWait) && bus.mem_done && !bus.mem_err);
    push          = (state_q == StWait) && bus.mem_done && !bus.mem_err && !redirect_valid;
    pop           = bus.out_valid && bus.out_ready && !redirect_valid;
    occ_next      = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    // Space is reserved at issue, so the FIFO can never overflow on the response.
    bus.mem_rd    = fetch_en && !redirect_valid && issue_state &&
                    (occ_next < (CW + 1)'(DEPTH));
    accept        = bus.mem_rd && !bus.mem_stall;
    inflight      = ((state_q == StWait) || (state_q == StDrop)) && !bus.mem_done;
    misaligned    = (redirect_pc % WIDTH'(INC)) != '0;
  end

  assign bus.mem_addr   = fetch_pc_q;
  assign bus.out_instr  = bus.out_valid ? fifo_instr_q[rptr_q]  : '0;
  assign bus.out_pc     = bus.out_valid ? fifo_pc_q[rptr_q]     : '0;
  assign bus.out_pc_inc = bus.out_valid ? fifo_pc_inc_q[rptr_q] : '0;
  assign count          = count_q;
  assign err            = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= WIDTH'(RESET_PC);
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else if (redirect_valid && (state_q != StHalt)) begin
      fetch_pc_q <= redirect_pc;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      if (misaligned) begin
        err_q   <= 1'b1;
        state_q <= inflight ? StDrop : StHalt;
      end else begin
        state_q <= inflight ? StDrop : StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tag_q      <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + WIDTH'(INC);
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (bus.mem_done) begin
            if (bus.mem_err) begin
              err_q   <= 1'b1;
              state_q <= StHalt;
            end else if (accept) begin
              tag_q      <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + WIDTH'(INC);
              state_q    <= StWait;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        // err can only be set here by a misaligned redirect, which must end in HALT.
        StDrop: begin
          if (bus.mem_done) state_q <= err_q ? StHalt : StIdle;
        end
        StHalt: state_q <= StHalt;
      endcase
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= occ_next[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wptr_q]  <= bus.mem_rdata;
      fifo_pc_q[wptr_q]     <= tag_q;
      fifo_pc_inc_q[wptr_q] <= tag_q + WIDTH'(INC);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle table for streaming/backpressure plus hand-written
// sequences for stall, redirect, error halt, PC wrap and misaligned redirect.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [2:0]  count;
  logic        err;

  fetch_queue_if #(.WIDTH(16)) bus ();

  fetch_queue #(.WIDTH(16), .DEPTH(4), .RESET_PC(0), .INC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .count          (count),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Memory model: answers the cycle after acceptance unless resp_en holds the answer back.
  logic        pend;
  logic [15:0] pend_addr;
  logic        resp_en;
  logic        err_en;
  logic [15:0] err_addr;

  assign bus.mem_done  = pend & resp_en;
  assign bus.mem_rdata = pend_addr ^ 16'hA5A5;
  assign bus.mem_err   = bus.mem_done & err_en & (pend_addr == err_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_addr <= 16'h0;
    end else begin
      if (bus.mem_done) pend <= 1'b0;
      if (bus.mem_rd && !bus.mem_stall) begin
        pend      <= 1'b1;
        pend_addr <= bus.mem_addr;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_pc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    bus.out_ready  = 1'b0;
    bus.mem_stall  = 1'b0;
    resp_en        = 1'b1;
    err_en         = 1'b0;
    err_addr       = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    popped.delete();
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_ov;
    logic [15:0] exp_pc;
    logic [15:0] exp_inc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[12];
  int   stall_left;
  int   n4;

  initial begin
    // Streaming with 1-cycle memory, then backpressure until the FIFO is full, then one pop.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000, 3'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0002, 3'd1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002, 16'h0004, 3'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004, 16'h0006, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h0006, 16'h0008, 3'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 16'h0006, 16'h0008, 3'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006, 16'h0008, 3'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006, 16'h0008, 3'd4};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006, 16'h0008, 3'd4};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h000E, 1'b1, 16'h0006, 16'h0008, 3'd4};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008, 16'h000A, 3'd3};

    rst = 1'b0;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_pc_inc", bus.out_pc_inc, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      fetch_en      = vecs[i].fe;
      bus.out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_mem_rd", i), bus.mem_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_out_pc_inc", i), bus.out_pc_inc, vecs[i].exp_inc);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
      if (vecs[i].exp_ov)
        chk($sformatf("vec%0d_out_instr", i), bus.out_instr, vecs[i].exp_pc ^ 16'hA5A5);
      tick();
    end

    // Stall three cycles on address 4: address held, exactly one push for PC 4.
    do_reset();
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    stall_left    = 3;
    for (int i = 0; i < 12; i++) begin
      bus.mem_stall = (bus.mem_addr == 16'h0004) && (stall_left > 0);
      #1;
      if (bus.mem_stall) begin
        stall_left--;
        chk("stall_addr_held", bus.mem_addr, 16'h0004);
      end
      tick();
    end
    bus.mem_stall = 1'b0;
    chk("stall_cycles", stall_left, 0);
    chk("stall_pop0", popped[0], 16'h0000);
    chk("stall_pop1", popped[1], 16'h0002);
    chk("stall_pop2", popped[2], 16'h0004);
    chk("stall_pop3", popped[3], 16'h0006);
    n4 = 0;
    foreach (popped[k]) if (popped[k] == 16'h0004) n4++;
    chk("stall_single_push", n4, 1);

    // Redirect while WAIT with two entries queued and PC 6 in flight.
    do_reset();
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    #1; tick();                        // c0: accept 0
    #1; tick();                        // c1: push 0, accept 2
    #1; tick();                        // c2: pop 0, push 2, accept 4
    bus.out_ready = 1'b0;
    #1; tick();                        // c3: push 4, accept 6
    resp_en        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    #1;
    chk("redir_count_before", count, 2);
    chk("redir_mem_rd", bus.mem_rd, 0);
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    #1;
    chk("redir_count_flushed", count, 0);
    chk("redir_drop_no_valid", bus.out_valid, 0);
    chk("redir_drop_no_rd", bus.mem_rd, 0);
    bus.out_ready = 1'b1;
    tick();
    #1;
    chk("redir_new_rd", bus.mem_rd, 1);
    chk("redir_new_addr", bus.mem_addr, 16'h0100);
    tick();
    #1; tick();
    #1;
    chk("redir_first_pc", bus.out_pc, 16'h0100);
    chk("redir_first_pc_inc", bus.out_pc_inc, 16'h0102);
    chk("redir_first_instr", bus.out_instr, 16'h0100 ^ 16'hA5A5);
    tick();

    // Error response for PC 8: halt, sticky err, remaining entries drain.
    do_reset();
    err_en        = 1'b1;
    err_addr      = 16'h0008;
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    #1; tick();
    #1; tick();
    #1; tick();
    bus.out_ready = 1'b0;
    #1; tick();
    #1; tick();
    #1;
    chk("err_resp_no_rd", bus.mem_rd, 0);
    tick();
    popped.delete();
    bus.out_ready = 1'b1;
    #1;
    chk("err_set", err, 1);
    chk("err_count", count, 3);
    chk("err_halt_no_rd", bus.mem_rd, 0);
    for (int i = 0; i < 4; i++) begin
      #1; tick();
    end
    #1;
    chk("err_drained_count", count, 0);
    chk("err_sticky", err, 1);
    chk("err_halt_still_no_rd", bus.mem_rd, 0);
    chk("err_drain_n", popped.size(), 3);
    chk("err_drain0", popped[0], 16'h0002);
    chk("err_drain1", popped[1], 16'h0004);
    chk("err_drain2", popped[2], 16'h0006);
    do_reset();
    #1;
    chk("err_cleared_by_reset", err, 0);

    // PC wrap at 0xFFFE.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    #1; tick();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    chk("wrap_addr", bus.mem_addr, 16'hFFFE);
    chk("wrap_rd", bus.mem_rd, 1);
    tick();
    #1;
    chk("wrap_next_addr", bus.mem_addr, 16'h0000);
    tick();
    #1;
    chk("wrap_out_pc", bus.out_pc, 16'hFFFE);
    chk("wrap_out_pc_inc", bus.out_pc_inc, 16'h0000);
    tick();

    // Misaligned redirect from IDLE: err and HALT.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0003;
    #1; tick();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    #1;
    chk("misalign_err", err, 1);
    chk("misalign_no_rd", bus.mem_rd, 0);
    tick();
    #1;
    chk("misalign_still_no_rd", bus.mem_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
